cpu_fetch_seq: RTL and testbench

- Parametrised fetch/decode sequencer for the 8-bit CPU family, generalised to arbitrary data/address width.
- Fetches opcodes and multi-byte immediates from the shared memory bus using a req/ready handshake, then presents a complete instruction (opcode plus assembled immediate) to the execute datapath.
- Holds that instruction until the datapath reports completion.
- Owns the program counter, jump/call redirection, halt, and bus-timeout fault detection.

---
 rtl/cpu_fetch_seq.sv | 164 ++++++++++++++++
 tb/tb_cpu_fetch_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_seq.sv
// Fetch/decode sequencer: pulls opcode + little-endian immediate over a req/ready bus and holds the instruction until execute completes.
// Optional single-step support (PAUSE state, step_mode/step ports) under CPU_FETCH_SEQ_STEP_EN.
module cpu_fetch_seq #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 16,
  parameter int                IMM_BYTES = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                TIMEOUT   = 15
) (
  input  logic                        clk,
  input  logic                        reset_cycle,
  output logic                        bus_req,
  output logic [ADDR_W-1:0]           bus_addr,
  input  logic                        bus_ready,
  input  logic [DATA_W-1:0]           bus_rdata,
  output logic [DATA_W-1:0]           ir,
  output logic [IMM_BYTES*DATA_W-1:0] imm,
  output logic                        instr_valid,
  input  logic                        exec_done,
  input  logic                        jump_req,
  input  logic [ADDR_W-1:0]           jump_target,
`ifdef CPU_FETCH_SEQ_STEP_EN
  input  logic                        step_mode,
  input  logic                        step,
`endif
  output logic [ADDR_W-1:0]           pc,
  output logic                        halted,
  output logic                        bus_err
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
`ifdef CPU_FETCH_SEQ_STEP_EN
    S_PAUSE,
`endif
    S_HALT,
    S_FAULT
  } state_t;

  localparam int              WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [2:0]      N_ADDR  = 3'(IMM_BYTES);

  localparam logic [DATA_W-1:0] OP_CALL   = DATA_W'(8'h01);
  localparam logic [DATA_W-1:0] OP_HLT    = DATA_W'(8'h05);
  localparam logic [DATA_W-1:0] OP_LDI_LO = DATA_W'(8'h10);
  localparam logic [DATA_W-1:0] OP_LDI_HI = DATA_W'(8'h17);
  localparam logic [DATA_W-1:0] OP_JMP_LO = DATA_W'(8'h18);
  localparam logic [DATA_W-1:0] OP_JMP_HI = DATA_W'(8'h1F);

  state_t          state, state_nxt;
  logic [2:0]      imm_left;
  logic [2:0]      n_imm;
  logic [2:0]      dec_n;
  logic [2:0]      imm_idx;
  logic [WC_W-1:0] wait_cnt;

  function automatic logic [2:0] imm_count(input logic [DATA_W-1:0] op);
    logic [2:0] n;
    n = 3'd0;
    if (op >= OP_LDI_LO && op <= OP_LDI_HI) begin
      n = 3'd1;
    end else if ((op >= OP_JMP_LO && op <= OP_JMP_HI) || op == OP_CALL) begin
      n = N_ADDR;
    end
    return n;
  endfunction

  assign dec_n   = imm_count(ir);
  // Byte slot for the next immediate beat: first beat lands in the lowest byte.
  assign imm_idx = n_imm - imm_left;

  assign bus_req     = (state == S_FETCH);
  assign bus_addr    = pc;
  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALT);
  assign bus_err     = (state == S_FAULT);

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      state <= S_START;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_START:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus_ready) begin
          if (imm_left == 3'd0)      state_nxt = S_DECODE;
          else if (imm_left == 3'd1) state_nxt = S_ISSUE;
        end else if (TIMEOUT != 0 && wait_cnt == WC_LAST) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        if (ir == OP_HLT)        state_nxt = S_HALT;
        else if (dec_n != 3'd0)  state_nxt = S_FETCH;
        else                     state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (exec_done) begin
`ifdef CPU_FETCH_SEQ_STEP_EN
          state_nxt = step_mode ? S_PAUSE : S_FETCH;
`else
          state_nxt = S_FETCH;
`endif
        end
      end
`ifdef CPU_FETCH_SEQ_STEP_EN
      S_PAUSE:  if (step) state_nxt = S_FETCH;
`endif
      S_HALT:   state_nxt = S_HALT;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_START;
    endcase
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      pc       <= RESET_PC;
      ir       <= '0;
      imm      <= '0;
      imm_left <= 3'd0;
      n_imm    <= 3'd0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus_ready) begin
            pc       <= pc + ADDR_W'(1);
            wait_cnt <= '0;
            if (imm_left == 3'd0) begin
              ir  <= bus_rdata;
              imm <= '0;
            end else begin
              for (int b = 0; b < IMM_BYTES; b++) begin
                if (imm_idx == 3'(b)) imm[b*DATA_W +: DATA_W] <= bus_rdata;
              end
              imm_left <= imm_left - 3'd1;
            end
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        S_DECODE: begin
          n_imm    <= dec_n;
          imm_left <= dec_n;
        end
        S_ISSUE: begin
          if (exec_done && jump_req) pc <= jump_target;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch_seq.sv
// Directed bench for cpu_fetch_seq: table of single-instruction runs plus hand sequences for timeout, wrap, halt and mid-fetch reset.
module tb_cpu_fetch_seq;

  logic        clk = 1'b0;
  logic        reset_cycle = 1'b1;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic        bus_ready = 1'b0;
  logic [7:0]  bus_rdata;
  logic [7:0]  ir;
  logic [15:0] imm;
  logic        instr_valid;
  logic        exec_done = 1'b1;
  logic        jump_req = 1'b0;
  logic [15:0] jump_target = 16'h0000;
  logic [15:0] pc;
  logic        halted;
  logic        bus_err;
`ifdef CPU_FETCH_SEQ_STEP_EN
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
`endif

  logic [7:0] mem [0:65535];
  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  bit stuck  = 1'b0;
  int rcnt   = 0;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int          waits;
    logic        jreq;
    logic [15:0] jtgt;
    logic [7:0]  exp_ir;
    logic [15:0] exp_imm;
    int          exp_lat;
    logic [15:0] exp_pc;
    logic [15:0] exp_next;
  } vec_t;

  vec_t vecs [7];

  cpu_fetch_seq dut (
    .clk         (clk),
    .reset_cycle (reset_cycle),
    .bus_req     (bus_req),
    .bus_addr    (bus_addr),
    .bus_ready   (bus_ready),
    .bus_rdata   (bus_rdata),
    .ir          (ir),
    .imm         (imm),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .jump_req    (jump_req),
    .jump_target (jump_target),
`ifdef CPU_FETCH_SEQ_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .pc          (pc),
    .halted      (halted),
    .bus_err     (bus_err)
  );

  assign bus_rdata = mem[bus_addr];

  always #5 clk = ~clk;

  // Memory responder: inserts wait_n not-ready cycles before each accepted beat.
  initial begin
    forever begin
      @(negedge clk);
      if (stuck || !bus_req) begin
        bus_ready = 1'b0;
        rcnt = 0;
      end else if (rcnt >= wait_n) begin
        bus_ready = 1'b1;
        rcnt = 0;
      end else begin
        bus_ready = 1'b0;
        rcnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_cycle = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset_cycle = 1'b0;
  endtask

  task automatic wait_iv(input string nm);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (instr_valid) break;
    end
    check(nm, 32'(instr_valid), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    string p;
    int    lat;
    p = $sformatf("v%0d", id);
    mem[0] = v.b0;
    mem[1] = v.b1;
    mem[2] = v.b2;
    jump_req    = v.jreq;
    jump_target = v.jtgt;
    wait_n      = v.waits;
    stuck       = 1'b0;
    do_reset();
    @(negedge clk);
    check({p, "_start_idle"}, 32'(bus_req), 32'd0);
    lat = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      lat++;
      if (instr_valid) break;
    end
    check({p, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({p, "_ir"}, 32'(ir), 32'(v.exp_ir));
    check({p, "_imm"}, 32'(imm), 32'(v.exp_imm));
    check({p, "_pc_issue"}, 32'(pc), 32'(v.exp_pc));
    @(negedge clk);
    check({p, "_valid_1cyc"}, 32'(instr_valid), 32'd0);
    check({p, "_next_req"}, 32'(bus_req), 32'd1);
    check({p, "_next_addr"}, 32'(bus_addr), 32'(v.exp_next));
  endtask

  initial begin
    int   n;
    vec_t r;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

    //          b0     b1     b2     w  jreq  jtgt      ir     imm       lat pc        next
    vecs[0] = '{8'h00, 8'h00, 8'h00, 0, 1'b0, 16'h0000, 8'h00, 16'h0000, 3,  16'h0001, 16'h0001};
    vecs[1] = '{8'h1A, 8'h34, 8'h12, 0, 1'b1, 16'h1234, 8'h1A, 16'h1234, 5,  16'h0003, 16'h1234};
    vecs[2] = '{8'h13, 8'hAB, 8'h00, 3, 1'b0, 16'h0000, 8'h13, 16'h00AB, 10, 16'h0002, 16'h0002};
    vecs[3] = '{8'h01, 8'hCD, 8'hAB, 1, 1'b1, 16'hABCD, 8'h01, 16'hABCD, 8,  16'h0003, 16'hABCD};
    vecs[4] = '{8'h17, 8'hFF, 8'h00, 0, 1'b0, 16'h0000, 8'h17, 16'h00FF, 4,  16'h0002, 16'h0002};
    vecs[5] = '{8'h20, 8'h99, 8'h00, 2, 1'b1, 16'h0040, 8'h20, 16'h0000, 5,  16'h0001, 16'h0040};
    vecs[6] = '{8'h1F, 8'h00, 8'h80, 0, 1'b0, 16'h0000, 8'h1F, 16'h8000, 5,  16'h0003, 16'h0003};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Asynchronous reset values from a busy state.
    @(negedge clk);
    reset_cycle = 1'b1;
    #1;
    check("rst_pc", 32'(pc), 32'h0000);
    check("rst_ir", 32'(ir), 32'h00);
    check("rst_imm", 32'(imm), 32'h0000);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);

    // Bus timeout: 15 wait cycles, then sticky fault.
    stuck = 1'b1;
    jump_req = 1'b0;
    mem[0] = 8'h00;
    do_reset();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_err) break;
      if (bus_req) n++;
    end
    check("to_wait_cycles", 32'(n), 32'd15);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_bus_req", 32'(bus_req), 32'd0);
    check("to_halted", 32'(halted), 32'd0);
    repeat (10) @(negedge clk);
    check("to_sticky", 32'(bus_err), 32'd1);
    check("to_pc_held", 32'(pc), 32'h0000);
    reset_cycle = 1'b1;
    #1;
    check("to_reset_clears", 32'(bus_err), 32'd0);
    stuck = 1'b0;

    // PC wrap: jump to 0xFFFF, LDI whose immediate sits at 0x0000.
    mem[0] = 8'h18; mem[1] = 8'hFF; mem[2] = 8'hFF; mem[16'hFFFF] = 8'h10;
    jump_req = 1'b1;
    jump_target = 16'hFFFF;
    wait_n = 0;
    do_reset();
    wait_iv("wrap_jmp_valid");
    @(negedge clk);
    check("wrap_fetch_addr", 32'(bus_addr), 32'hFFFF);
    jump_req = 1'b0;
    mem[0] = 8'h55;
    @(negedge clk);
    check("wrap_pc_zero", 32'(pc), 32'h0000);
    wait_iv("wrap_ldi_valid");
    check("wrap_ir", 32'(ir), 32'h10);
    check("wrap_imm", 32'(imm), 32'h0055);
    check("wrap_pc_issue", 32'(pc), 32'h0001);
    @(negedge clk);
    check("wrap_next_addr", 32'(bus_addr), 32'h0001);

    // HLT: halted, no further bus traffic.
    mem[0] = 8'h05;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("hlt_halted", 32'(halted), 32'd1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_req || instr_valid || !halted) n++;
    end
    check("hlt_quiet_cycles", 32'(n), 32'd0);
    check("hlt_pc", 32'(pc), 32'h0001);
    check("hlt_bus_err", 32'(bus_err), 32'd0);

    // Reset during the JMP immediate fetch discards the partial immediate.
    mem[0] = 8'h18; mem[1] = 8'h77; mem[2] = 8'h66;
    jump_req = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_req && bus_addr == 16'h0002) break;
    end
    check("midrst_addr", 32'(bus_addr), 32'h0002);
    check("midrst_partial_imm", 32'(imm), 32'h0077);
    reset_cycle = 1'b1;
    #1;
    check("midrst_imm", 32'(imm), 32'h0000);
    check("midrst_pc", 32'(pc), 32'h0000);
    check("midrst_ir", 32'(ir), 32'h00);
    check("midrst_bus_req", 32'(bus_req), 32'd0);
    r = '{8'h18, 8'h77, 8'h66, 0, 1'b0, 16'h0000, 8'h18, 16'h6677, 5, 16'h0003, 16'h0003};
    run_vec(r, 90);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
